// File: rtl/i2c_seg_ctrl.sv
// I2C write-frame decoder feeding a small register file (VALUE/CTRL/BLINK)
// and a registered 7-segment driver with hex/raw modes, decimal point and blink.
module i2c_seg_ctrl #(
    parameter int NUM_REGS   = 3,
    parameter int PRESCALE_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       data_valid,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] seg_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {IDLE, PTR, DATA} state_t;

    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    state_t                  state_q, state_d;
    logic [7:0]              ptr_q, ptr_d;
    logic [7:0]              value_q, value_d;
    logic [7:0]              ctrl_q, ctrl_d;
    logic [7:0]              blink_q, blink_d;
    logic [PRESCALE_W-1:0]   prescale_q;
    logic [7:0]              blink_cnt_q;
    logic                    phase_q;
    logic [7:0]              seg_q, seg_d;
    logic                    busy_q;
    logic                    tick;
    logic [3:0]              nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // Start overrides everything (including a coincident byte); stop closes the
    // frame only after any coincident byte has been handled in the current state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        value_d = value_q;
        ctrl_d  = ctrl_q;
        blink_d = blink_q;
        if (start) begin
            state_d = PTR;
        end else begin
            if (data_valid) begin
                case (state_q)
                    PTR: begin
                        ptr_d   = data;
                        state_d = DATA;
                    end
                    DATA: begin
                        if (ptr_q < NUM_REGS_B) begin
                            case (ptr_q)
                                8'd0:    value_d = data;
                                8'd1:    ctrl_d  = data;
                                default: blink_d = data;
                            endcase
                        end
                        ptr_d = ptr_q + 8'd1;
                    end
                    default: ;
                endcase
            end
            if (stop) begin
                state_d = IDLE;
            end
        end
    end

    assign tick = &prescale_q;
    assign nib  = ctrl_q[4] ? value_q[7:4] : value_q[3:0];

    always_comb begin
        seg_d = 8'h00;
        if (ctrl_q[3] && !(ctrl_q[1] && phase_q)) begin
            if (ctrl_q[0]) begin
                seg_d = {value_q[7] | ctrl_q[2], value_q[6:0]};
            end else begin
                seg_d = {ctrl_q[2], hex7(nib)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 8'h00;
            value_q     <= 8'h00;
            ctrl_q      <= 8'h08;
            blink_q     <= 8'h00;
            prescale_q  <= '0;
            blink_cnt_q <= 8'h00;
            phase_q     <= 1'b0;
            seg_q       <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            value_q    <= value_d;
            ctrl_q     <= ctrl_d;
            blink_q    <= blink_d;
            prescale_q <= prescale_q + 1'b1;
            if (tick) begin
                if (blink_cnt_q >= blink_q) begin
                    blink_cnt_q <= 8'h00;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 8'd1;
                end
            end
            seg_q  <= seg_d;
            busy_q <= (state_d != IDLE);
        end
    end

    assign seg_o  = seg_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_i2c_seg_ctrl.sv
// Directed bench for i2c_seg_ctrl: table of write frames plus hand-written
// sequences for simultaneous events, reset mid-frame and blinking.
module tb_i2c_seg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       data_valid = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] seg_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_seg_ctrl #(.NUM_REGS(3), .PRESCALE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .data_valid (data_valid),
        .start      (start),
        .stop       (stop),
        .seg_o      (seg_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ptr;
        int          n;
        logic [31:0] bytes;
        logic [7:0]  exp_seg;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic s, input logic p, input logic v, input logic [7:0] d);
        @(negedge clk);
        start = s; stop = p; data_valid = v; data = d;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; data_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        pulse(1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic frame(input logic [7:0] ptr, input int n, input logic [31:0] bytes);
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        send(ptr);
        for (int i = 0; i < n; i++) send(bytes[31-8*i -: 8]);
        pulse(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] v;
        int         waited;

        vecs[0]  = '{8'h00, 1, 32'hA5000000, 8'h6D};
        vecs[1]  = '{8'h01, 1, 32'h18000000, 8'h77};
        vecs[2]  = '{8'h00, 4, 32'h128D0733, 8'h92};
        vecs[3]  = '{8'h01, 1, 32'h0C000000, 8'hDB};
        vecs[4]  = '{8'h01, 1, 32'h19000000, 8'h12};
        vecs[5]  = '{8'hFE, 3, 32'h55667700, 8'h77};
        vecs[6]  = '{8'h01, 2, 32'h08000000, 8'h07};
        vecs[7]  = '{8'h00, 2, 32'hF0180000, 8'h71};
        vecs[8]  = '{8'h01, 1, 32'h08000000, 8'h3F};
        vecs[9]  = '{8'h01, 1, 32'h00000000, 8'h00};
        vecs[10] = '{8'h01, 1, 32'hE8000000, 8'h3F};

        // Reset state and release
        repeat (3) @(negedge clk);
        chk("reset_seg", seg_o, 8'h00);
        chk("reset_busy", {7'h0, busy_o}, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("post_reset_seg", seg_o, 8'h3F);
        chk("post_reset_busy", {7'h0, busy_o}, 8'h00);

        for (int i = 0; i < 11; i++) begin
            frame(vecs[i].ptr, vecs[i].n, vecs[i].bytes);
            $display("vec %0d: ptr=0x%02h n=%0d bytes=0x%08h seg=0x%02h exp=0x%02h",
                     i, vecs[i].ptr, vecs[i].n, vecs[i].bytes, seg_o, vecs[i].exp_seg);
            chk($sformatf("vec%0d_seg", i), seg_o, vecs[i].exp_seg);
            chk($sformatf("vec%0d_busy", i), {7'h0, busy_o}, 8'h00);
        end

        // Repeated start reloads the pointer
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        chk("busy_after_start", {7'h0, busy_o}, 8'h01);
        send(8'h00);
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h01);
        send(8'h00);
        pulse(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        $display("seq rep_start: seg=0x%02h", seg_o);
        chk("rep_start_seg", seg_o, 8'h00);
        frame(8'h01, 1, 32'h18000000);
        chk("rep_start_value_kept", seg_o, 8'h71);

        // Start coincident with a data byte: byte dropped, state PTR
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h00);
        pulse(1'b1, 1'b0, 1'b1, 8'h55);
        chk("start_dv_busy", {7'h0, busy_o}, 8'h01);
        pulse(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        $display("seq start_dv: seg=0x%02h", seg_o);
        chk("start_dv_seg", seg_o, 8'h71);

        // Stop coincident with a data byte: byte written, then idle
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h00);
        pulse(1'b0, 1'b1, 1'b1, 8'h3C);
        @(negedge clk);
        $display("seq stop_dv: seg=0x%02h busy=%0b", seg_o, busy_o);
        chk("stop_dv_seg", seg_o, 8'h4F);
        chk("stop_dv_busy", {7'h0, busy_o}, 8'h00);

        // Idle ignores bytes
        send(8'h99);
        @(negedge clk);
        chk("idle_ignore_seg", seg_o, 8'h4F);

        // Start with stop: start wins
        pulse(1'b1, 1'b1, 1'b0, 8'h00);
        chk("start_stop_busy", {7'h0, busy_o}, 8'h01);
        send(8'h01);
        send(8'h08);
        pulse(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        $display("seq start_stop: seg=0x%02h", seg_o);
        chk("start_stop_seg", seg_o, 8'h39);

        // Asynchronous reset in the middle of a data phase
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h00);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_seg", seg_o, 8'h00);
        chk("async_rst_busy", {7'h0, busy_o}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h55);
        send(8'h00);
        @(negedge clk);
        $display("seq reset_mid: seg=0x%02h busy=%0b", seg_o, busy_o);
        chk("post_rst_ignore_seg", seg_o, 8'h3F);
        chk("post_rst_ignore_busy", {7'h0, busy_o}, 8'h00);

        // Blink with BLINK=0: phase flips every prescaler wrap (16 clocks)
        frame(8'h01, 1, 32'h0A000000);
        v = seg_o;
        waited = 0;
        while (seg_o == v && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL blink_toggle_timeout: got no change expected change within 40 clocks");
        end else begin
            v = seg_o;
            for (int k = 0; k < 3; k++) begin
                repeat (8) @(negedge clk);
                chk($sformatf("blink_hold%0d", k), seg_o, v);
                repeat (8) @(negedge clk);
                v = (v == 8'h3F) ? 8'h00 : 8'h3F;
                $display("blink period %0d: seg=0x%02h exp=0x%02h", k, seg_o, v);
                chk($sformatf("blink_flip%0d", k), seg_o, v);
            end
        end

        // Blink disabled: steady display
        frame(8'h01, 1, 32'h08000000);
        for (int k = 0; k < 8; k++) begin
            repeat (5) @(negedge clk);
            chk($sformatf("steady%0d", k), seg_o, 8'h3F);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
